// File: rtl/tl_ul_scratchpad_responder_if.sv
// TileLink-UL A/D channel pair between a client (master) and a manager (slave).
interface tl_ul_scratchpad_responder_if #(
  parameter int ADDR_W = 30,
  parameter int SRC_W  = 7
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [3:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;
  logic              a_corrupt;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [3:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [63:0]       d_data;
  logic              d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_scratchpad_responder.sv
// TL-UL scratchpad manager: single-beat Get/Put served from a 64-bit word array,
// responses returned in order through a 2-entry queue.
module tl_ul_scratchpad_responder #(
  parameter int              ADDR_W      = 30,
  parameter int              SRC_W       = 7,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h0800_0000,
  parameter int              DEPTH_WORDS = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  tl_ul_scratchpad_responder_if.slave bus,
  output logic [7:0]                  denied_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int REG_W = IDX_W + 3;

  typedef struct packed {
    logic [2:0]       op;
    logic [3:0]       size;
    logic [SRC_W-1:0] src;
    logic             den;
    logic [63:0]      data;
    logic             corrupt;
  } rsp_t;

  logic [63:0] r_mem [DEPTH_WORDS];
  rsp_t        r_q   [2];
  logic        r_head;
  logic [1:0]  r_cnt;
  logic        r_rdy;
  logic [7:0]  r_dcnt;

  logic             w_afire, w_dfire, w_get, w_put, w_bad_op, w_oob, w_misalign, w_den, w_we;
  logic             w_tail;
  logic [1:0]       w_cnt_nxt;
  logic [7:0]       w_nat;
  logic [IDX_W-1:0] w_idx;
  rsp_t             w_rsp, w_head;
  logic             w_unused;

  assign w_unused  = ^{bus.a_param, bus.a_corrupt};
  assign w_afire   = bus.a_valid & r_rdy;
  assign w_dfire   = (r_cnt != 2'd0) & bus.d_ready;
  assign w_cnt_nxt = r_cnt + {1'b0, w_afire} - {1'b0, w_dfire};
  assign w_tail    = r_head ^ r_cnt[0];

  assign w_get    = bus.a_opcode == 3'd4;
  assign w_put    = (bus.a_opcode == 3'd0) | (bus.a_opcode == 3'd1);
  assign w_bad_op = ~(w_get | w_put);
  // Region is size-aligned, so range check reduces to comparing the upper bits.
  assign w_oob    = bus.a_address[ADDR_W-1:REG_W] != BASE_ADDR[ADDR_W-1:REG_W];
  assign w_idx    = bus.a_address[REG_W-1:3];

  always_comb begin
    w_nat      = 8'h00;
    w_misalign = 1'b1;
    case (bus.a_size)
      4'd0: begin w_nat = 8'h01 << bus.a_address[2:0];          w_misalign = 1'b0; end
      4'd1: begin w_nat = 8'h03 << {bus.a_address[2:1], 1'b0};  w_misalign = bus.a_address[0]; end
      4'd2: begin w_nat = 8'h0F << {bus.a_address[2], 2'b00};   w_misalign = |bus.a_address[1:0]; end
      4'd3: begin w_nat = 8'hFF;                                w_misalign = |bus.a_address[2:0]; end
      default: ;
    endcase
  end

  assign w_den = w_bad_op | (bus.a_size > 4'd3) | w_misalign | w_oob |
                 ((bus.a_opcode == 3'd0) & (bus.a_mask != w_nat));
  assign w_we  = w_afire & w_put & ~w_den & ~reset;

  // Read is taken from the array at fire, so a Put fired the previous cycle is already visible.
  always_comb begin
    w_rsp         = '0;
    w_rsp.op      = {2'b00, w_get};
    w_rsp.size    = bus.a_size;
    w_rsp.src     = bus.a_source;
    w_rsp.den     = w_den;
    w_rsp.data    = (w_get & ~w_den) ? r_mem[w_idx] : 64'h0;
    w_rsp.corrupt = w_den & w_get;
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 8; b++)
      if (w_we && bus.a_mask[b]) r_mem[w_idx][b*8 +: 8] <= bus.a_data[b*8 +: 8];
  end

  always_ff @(posedge clock) begin
    if (w_afire) r_q[w_tail] <= w_rsp;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b0;
      r_dcnt <= 8'd0;
    end else begin
      if (w_dfire) r_head <= ~r_head;
      r_cnt <= w_cnt_nxt;
      r_rdy <= w_cnt_nxt != 2'd2;
      if (w_afire && w_den && r_dcnt != 8'hFF) r_dcnt <= r_dcnt + 8'd1;
    end
  end

  assign w_head       = (r_cnt != 2'd0) ? r_q[r_head] : '0;
  assign bus.a_ready  = r_rdy;
  assign bus.d_valid  = r_cnt != 2'd0;
  assign bus.d_opcode = w_head.op;
  assign bus.d_param  = 2'b00;
  assign bus.d_size   = w_head.size;
  assign bus.d_source = w_head.src;
  assign bus.d_denied = w_head.den;
  assign bus.d_data   = w_head.data;
  assign bus.d_corrupt = w_head.corrupt;
  assign denied_count = r_dcnt;
endmodule

// File: tb/tb_tl_ul_scratchpad_responder.sv
// Directed + randomized bench for the TL-UL scratchpad responder against a queue/array model.
module tb_tl_ul_scratchpad_responder;
  localparam int     ADDR_W = 30;
  localparam int     SRC_W  = 7;
  localparam int     DEPTH  = 512;
  localparam longint BASE   = 64'h0800_0000;

  typedef struct packed {
    logic [2:0]       op;
    logic [3:0]       size;
    logic [SRC_W-1:0] src;
    logic             den;
    logic [63:0]      data;
    logic             corrupt;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dcnt;

  tl_ul_scratchpad_responder_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus();

  tl_ul_scratchpad_responder #(
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .BASE_ADDR(30'h0800_0000), .DEPTH_WORDS(DEPTH)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus), .denied_count(dcnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  rsp_t        q[$];
  logic [63:0] mem[longint];
  bit          m_rdy = 1'b0;
  int          m_dcnt = 0;

  function automatic int nat_mask(int size, int off);
    int nb = 1 << size;
    return (((1 << nb) - 1) << off) & 255;
  endfunction

  function automatic bit is_denied(int op, int size, longint addr, int mask);
    if (!(op == 0 || op == 1 || op == 4)) return 1'b1;
    if (size > 3) return 1'b1;
    if (addr % (64'd1 << size) != 0) return 1'b1;
    if (addr < BASE || addr >= BASE + DEPTH * 8) return 1'b1;
    if (op == 0 && mask != nat_mask(size, int'(addr % 8))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic accept(int op, int size, longint addr, int mask, logic [63:0] data, int src);
    rsp_t        r;
    bit          den = is_denied(op, size, addr, mask);
    longint      idx = (addr - BASE) / 8;
    logic [63:0] w;
    r.op      = (op == 4) ? 3'd1 : 3'd0;
    r.size    = 4'(size);
    r.src     = SRC_W'(src);
    r.den     = den;
    r.corrupt = den && op == 4;
    r.data    = 64'h0;
    if (!den && op == 4) r.data = mem.exists(idx) ? mem[idx] : 64'h0;
    if (!den && op != 4) begin
      w = mem.exists(idx) ? mem[idx] : 64'h0;
      for (int b = 0; b < 8; b++) if (mask[b]) w[b*8 +: 8] = data[b*8 +: 8];
      mem[idx] = w;
    end
    if (den && m_dcnt < 255) m_dcnt++;
    q.push_back(r);
  endtask

  task automatic check_outputs(string tag);
    rsp_t        h = (q.size() > 0) ? q[0] : '0;
    logic [91:0] exp_v, obs_v;
    exp_v = {m_rdy && q.size() < 2, q.size() > 0, h.op, 2'b00, h.size, h.src, h.den, h.data,
             h.corrupt, 8'(m_dcnt)};
    obs_v = {bus.a_ready, bus.d_valid, bus.d_opcode, bus.d_param, bus.d_size, bus.d_source,
             bus.d_denied, bus.d_data, bus.d_corrupt, dcnt};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_lit(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: decide fires from what the DUT sees before the edge, update model, check after.
  task automatic step(string tag);
    bit          afire = bus.a_valid && m_rdy && q.size() < 2;
    bit          dfire = q.size() > 0 && bus.d_ready;
    int          op = int'(bus.a_opcode), sz = int'(bus.a_size), src = int'(bus.a_source);
    int          mask = int'(bus.a_mask);
    longint      addr = longint'(bus.a_address);
    logic [63:0] data = bus.a_data;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dcnt = 0;
      m_rdy  = 1'b0;
    end else begin
      if (dfire) void'(q.pop_front());
      if (afire) accept(op, sz, addr, mask, data, src);
      m_rdy = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic set_a(int op, int size, longint addr, int mask, logic [63:0] data, int src);
    bus.a_opcode  = 3'(op);
    bus.a_size    = 4'(size);
    bus.a_address = ADDR_W'(addr);
    bus.a_mask    = 8'(mask);
    bus.a_data    = data;
    bus.a_source  = SRC_W'(src);
  endtask

  task automatic wait_fire(string tag);
    bit fired = 1'b0;
    bus.a_valid = 1'b1;
    for (int i = 0; i < 50 && !fired; i++) begin
      fired = m_rdy && q.size() < 2;
      step(tag);
    end
    bus.a_valid = 1'b0;
    checks++;
    assert (fired) else begin
      failures++;
      $error("FAIL %s_timeout observed=no_fire expected=fire", tag);
    end
  endtask

  task automatic issue(string tag, int op, int size, longint addr, int mask,
                       logic [63:0] data, int src);
    set_a(op, size, addr, mask, data, src);
    wait_fire(tag);
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.a_param = 3'd0; bus.a_corrupt = 1'b0; bus.d_ready = 1'b1;
    set_a(0, 0, BASE, 0, 64'h0, 0);

    repeat (3) step("reset");
    rst = 1'b0;
    step("post_reset");

    issue("put_full", 0, 3, BASE, 8'hFF, 64'h1122334455667788, 5);
    issue("get_full", 4, 3, BASE, 0, 64'h0, 6);
    check_lit("get_full_data", bus.d_data, 64'h1122334455667788);
    repeat (2) step("idle");

    issue("put_partial", 1, 3, BASE, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 7);
    issue("get_partial", 4, 3, BASE, 0, 64'h0, 8);
    check_lit("get_partial_data", bus.d_data, 64'h11223344_BBBBBBBB);
    repeat (2) step("idle");

    for (int i = 0; i < 6; i++) begin
      issue("b2b_put", 0, 3, BASE + 8, 8'hFF, {$urandom, $urandom}, 10 + i);
      issue("b2b_get", 4, 3, BASE + 8, 0, 64'h0, 20 + i);
    end
    repeat (2) step("idle");

    bus.d_ready = 1'b0;
    issue("stall_g1", 4, 3, BASE, 0, 64'h0, 31);
    issue("stall_g2", 4, 3, BASE + 8, 0, 64'h0, 32);
    set_a(4, 3, BASE, 0, 64'h0, 33);
    bus.a_valid = 1'b1;
    repeat (3) step("stall_hold");
    bus.d_ready = 1'b1;
    wait_fire("stall_g3");
    repeat (3) step("drain");

    issue("deny_oob", 4, 3, BASE + DEPTH * 8, 0, 64'h0, 40);
    issue("deny_size", 4, 4, BASE, 0, 64'h0, 41);
    issue("deny_misal", 0, 2, BASE + 2, 8'h0F, 64'hDEADBEEF_DEADBEEF, 42);
    issue("deny_op", 2, 3, BASE, 8'hFF, 64'h0, 43);
    repeat (2) step("idle");
    check_lit("deny_count4", 64'(dcnt), 64'd4);
    issue("deny_keep", 4, 3, BASE, 0, 64'h0, 44);
    check_lit("deny_keep_data", bus.d_data, 64'h11223344_BBBBBBBB);
    for (int i = 0; i < 260; i++) issue("deny_sat", 2, 3, BASE, 8'hFF, 64'h0, i & 127);
    repeat (2) step("idle");
    check_lit("deny_sat255", 64'(dcnt), 64'd255);

    bus.d_ready = 1'b0;
    issue("pend_g1", 4, 3, BASE, 0, 64'h0, 50);
    issue("pend_g2", 4, 3, BASE + 8, 0, 64'h0, 51);
    rst = 1'b1;
    step("mid_reset");
    check_lit("mid_reset_dvalid", 64'(bus.d_valid), 64'd0);
    check_lit("mid_reset_dcnt", 64'(dcnt), 64'd0);
    rst = 1'b0;
    bus.d_ready = 1'b1;
    step("post_mid_reset");
    issue("reread", 4, 3, BASE, 0, 64'h0, 52);
    check_lit("reread_data", bus.d_data, 64'h11223344_BBBBBBBB);
    repeat (2) step("idle");

    for (int w = 0; w < 16; w++)
      issue("init", 0, 3, BASE + w * 8, 8'hFF, {$urandom, $urandom}, w);
    for (int i = 0; i < 600; i++) begin
      int     pick = int'($urandom_range(0, 9));
      int     op   = pick < 3 ? 0 : pick < 5 ? 1 : pick < 9 ? 4 : 2 + int'($urandom_range(0, 1)) * 3;
      int     sz   = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
      int     wd   = int'($urandom_range(0, 18));
      int     off  = int'($urandom_range(0, 7));
      int     mask = int'($urandom_range(0, 255));
      longint addr;
      if (sz <= 3 && $urandom_range(0, 7) != 0) off = (off >> sz) << sz;
      addr = (wd < 16) ? BASE + wd * 8 + off : (wd == 16) ? BASE - 8 + off : BASE + DEPTH * 8 + off;
      if (op == 0 && sz <= 3 && $urandom_range(0, 9) != 0) mask = nat_mask(sz, off);
      set_a(op, sz, addr, mask, {$urandom, $urandom}, int'($urandom_range(0, 127)));
      bus.a_valid = $urandom_range(0, 3) != 0;
      bus.d_ready = $urandom_range(0, 3) != 0;
      step("random");
    end
    bus.a_valid = 1'b0;
    bus.d_ready = 1'b1;
    repeat (3) step("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
